// File: rtl/sss_descrambler_core_if.sv
// Word-stream bundle for sss_descrambler_core: qualified input word plus mode
// controls in, qualified result word and lock flag out.
interface sss_descrambler_core_if #(
  parameter int DATA_W = 60
);
  // Valid-only stream, no backpressure: a word transfers on every clk_div
  // cycle where in_valid (or out_valid) is high; data is ignored otherwise.
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              mode;
  logic              bypass;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_locked;

  modport master (
    output in_valid, in_data, mode, bypass,
    input  out_valid, out_data, out_locked
  );

  modport slave (
    input  in_valid, in_data, mode, bypass,
    output out_valid, out_data, out_locked
  );
endinterface

// File: rtl/sss_descrambler_core.sv
// Self-synchronous scrambler/descrambler, polynomial x^TAP_A + x^TAP_B + 1.
// Define SCR_INPUT_REG_EN to add an input register stage (2-clock latency).
module sss_descrambler_core #(
  parameter int DATA_W = 60,
  parameter int TAP_A  = 58,
  parameter int TAP_B  = 39
) (
  input logic                  clk_div,
  input logic                  rst,
  sss_descrambler_core_if.slave bus
);
  localparam int LOCK_WORDS = (TAP_A + DATA_W - 1) / DATA_W;
  localparam int CNT_W      = $clog2(LOCK_WORDS + 1);
  localparam int EXT_W      = TAP_A + DATA_W;

  logic              v_w;
  logic [DATA_W-1:0] d_w;
  logic              m_w;
  logic              b_w;

`ifdef SCR_INPUT_REG_EN
  logic              in_valid_q;
  logic [DATA_W-1:0] in_data_q;
  logic              mode_in_q;
  logic              bypass_q;

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
      mode_in_q  <= 1'b0;
      bypass_q   <= 1'b0;
    end else begin
      in_valid_q <= bus.in_valid;
      in_data_q  <= bus.in_data;
      mode_in_q  <= bus.mode;
      bypass_q   <= bus.bypass;
    end
  end

  assign v_w = in_valid_q;
  assign d_w = in_data_q;
  assign m_w = mode_in_q;
  assign b_w = bypass_q;
`else
  assign v_w = bus.in_valid;
  assign d_w = bus.in_data;
  assign m_w = bus.mode;
  assign b_w = bus.bypass;
`endif

  logic [TAP_A-1:0]  hist_q, hist_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q;
  logic              out_locked_q, out_locked_d;
  logic              mode_q;
  logic              mode_chg;

  assign mode_chg = v_w && (m_w != mode_q);

  // ext holds {this word's scrambled-domain bits, history}, oldest bit at 0,
  // so stream bit n-T for word bit i always lives at ext[TAP_A+i-T].
  always_comb begin
    logic [EXT_W-1:0] ext;
    logic             tap;
    ext        = {{DATA_W{1'b0}}, (mode_chg ? {TAP_A{1'b0}} : hist_q)};
    out_data_d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      tap = ext[TAP_A + i - TAP_B] ^ ext[i];
      if (b_w) begin
        out_data_d[i]  = d_w[i];
        ext[TAP_A + i] = d_w[i];
      end else begin
        out_data_d[i]  = d_w[i] ^ tap;
        ext[TAP_A + i] = m_w ? out_data_d[i] : d_w[i];
      end
    end
    hist_d = ext[EXT_W-1 -: TAP_A];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (mode_chg) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_W'(LOCK_WORDS)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    out_locked_d = (cnt_d == CNT_W'(LOCK_WORDS));
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      hist_q       <= '0;
      out_data_q   <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_locked_q <= 1'b0;
      mode_q       <= 1'b0;
    end else begin
      out_valid_q <= v_w;
      if (v_w) begin
        hist_q       <= hist_d;
        out_data_q   <= out_data_d;
        cnt_q        <= cnt_d;
        out_locked_q <= out_locked_d;
        mode_q       <= m_w;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_locked = out_locked_q;
endmodule

// File: tb/tb_sss_descrambler_core.sv
// Directed bench for sss_descrambler_core: 60-bit scrambler feeding a 60-bit
// descrambler in loopback, plus a separate 20-bit instance.
module tb_sss_descrambler_core;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  sss_descrambler_core_if #(.DATA_W(60)) a_if ();
  sss_descrambler_core_if #(.DATA_W(60)) b_if ();
  sss_descrambler_core_if #(.DATA_W(20)) c_if ();

  sss_descrambler_core u_a (.clk_div(clk), .rst(rst), .bus(a_if));
  sss_descrambler_core u_b (.clk_div(clk), .rst(rst), .bus(b_if));
  sss_descrambler_core #(.DATA_W(20)) u_c (.clk_div(clk), .rst(rst), .bus(c_if));

  // u_b descrambles whatever u_a emits.
  assign b_if.in_valid = a_if.out_valid;
  assign b_if.in_data  = a_if.out_data;
  assign b_if.mode     = 1'b0;
  assign b_if.bypass   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic [63:0] d, input logic m, input logic b);
    @(negedge clk);
    a_if.in_valid = v;
    a_if.in_data  = d[59:0];
    a_if.mode     = m;
    a_if.bypass   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic step_c(input logic v, input logic [19:0] d, input logic m);
    @(negedge clk);
    c_if.in_valid = v;
    c_if.in_data  = d;
    c_if.mode     = m;
    c_if.bypass   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [59:0] exp_q[$];
  logic [59:0] lb_word;
  logic [19:0] c_in   [7];
  logic        c_mode [7];
  logic [19:0] c_exp  [7];
  logic        c_lock [7];
  logic [19:0] c_prev;
  logic [59:0] byp_in [3];
  int          gap;

  initial begin
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.mode = 1'b0; a_if.bypass = 1'b0;
    c_if.in_valid = 1'b0; c_if.in_data = '0; c_if.mode = 1'b0; c_if.bypass = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid",  64'(a_if.out_valid),  64'd0);
    chk("reset_data",   64'(a_if.out_data),   64'd0);
    chk("reset_locked", 64'(a_if.out_locked), 64'd0);
    chk("reset_c_lock", 64'(c_if.out_locked), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Scramble all-zero words from zero history: output stays zero, lock on word 1.
    for (int k = 0; k < 4; k++) begin
      step_a(1'b1, 64'd0, 1'b1, 1'b0);
      chk($sformatf("zero_data_w%0d", k),  64'(a_if.out_data),   64'd0);
      chk($sformatf("zero_valid_w%0d", k), 64'(a_if.out_valid),  64'd1);
      chk($sformatf("zero_lock_w%0d", k),  64'(a_if.out_locked), 64'd1);
    end
    step_a(1'b0, 64'd0, 1'b1, 1'b0);
    chk("zero_idle_valid", 64'(a_if.out_valid), 64'd0);

    // 20-bit descrambler with random gaps, then a switch to scramble mode.
    // x[0]=1 -> d errors at 0, 39, 58; x[79]=1 -> d[79]; x[79] left in the
    // history must not leak into the zero-history scramble that follows.
    c_in   = '{20'h00001, 20'h0, 20'h0, 20'h80000, 20'h0, 20'h0, 20'h0};
    c_mode = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    c_exp  = '{20'h00001, 20'h80000, 20'h40000, 20'h80000, 20'h0, 20'h0, 20'h0};
    c_lock = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    c_prev = 20'h0;
    for (int k = 0; k < 7; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step_c(1'b0, 20'hfffff, c_mode[k]);
        chk($sformatf("c_gap_valid_w%0d", k), 64'(c_if.out_valid), 64'd0);
        chk($sformatf("c_gap_hold_w%0d", k),  64'(c_if.out_data),  64'(c_prev));
      end
      step_c(1'b1, c_in[k], c_mode[k]);
      chk($sformatf("c_valid_w%0d", k), 64'(c_if.out_valid),  64'd1);
      chk($sformatf("c_data_w%0d", k),  64'(c_if.out_data),   64'(c_exp[k]));
      chk($sformatf("c_lock_w%0d", k),  64'(c_if.out_locked), 64'(c_lock[k]));
      c_prev = c_exp[k];
    end
    step_c(1'b0, 20'h0, 1'b1);

    // Bypass words 0-2 then descramble word 3 from the bypassed history:
    // x[179]=1 -> d[218] (word 3 bit 38) and d[237] (word 3 bit 57).
    byp_in = '{60'habc, 60'h5, 60'h800000000000000};
    for (int k = 0; k < 3; k++) begin
      step_a(1'b1, 64'(byp_in[k]), 1'b0, 1'b1);
      chk($sformatf("byp_data_w%0d", k), 64'(a_if.out_data), 64'(byp_in[k]));
    end
    step_a(1'b1, 64'd0, 1'b0, 1'b0);
    chk("byp_desc_w3", 64'(a_if.out_data),   (64'd1 << 38) | (64'd1 << 57));
    chk("byp_lock_w3", 64'(a_if.out_locked), 64'd1);
    step_a(1'b1, 64'd0, 1'b0, 1'b0);
    chk("byp_desc_w4", 64'(a_if.out_data), 64'd0);
    step_a(1'b0, 64'd0, 1'b0, 1'b0);

    // Single flipped bit at stream index 100 -> errors at 100, 139, 158.
    pulse_rst();
    step_a(1'b1, 64'd0, 1'b0, 1'b0);
    chk("err_w0", 64'(a_if.out_data), 64'd0);
    step_a(1'b1, 64'd1 << 40, 1'b0, 1'b0);
    chk("err_w1", 64'(a_if.out_data), 64'd1 << 40);
    step_a(1'b1, 64'd0, 1'b0, 1'b0);
    chk("err_w2", 64'(a_if.out_data), (64'd1 << 19) | (64'd1 << 38));
    step_a(1'b1, 64'd0, 1'b0, 1'b0);
    chk("err_w3", 64'(a_if.out_data), 64'd0);
    step_a(1'b0, 64'd0, 1'b0, 1'b0);

    // Loopback: scrambler u_a into descrambler u_b, one word per clock.
    pulse_rst();
    for (int k = 0; k < 200; k++) begin
      lb_word = {$urandom, $urandom};
      exp_q.push_back(lb_word);
      step_a(1'b1, 64'(lb_word), 1'b1, 1'b0);
      if (k > 0) begin
        chk($sformatf("loop_w%0d", k - 1), 64'(b_if.out_data), 64'(exp_q.pop_front()));
      end
    end
    step_a(1'b0, 64'd0, 1'b1, 1'b0);
    chk("loop_w199", 64'(b_if.out_data), 64'(exp_q.pop_front()));
    chk("loop_b_valid", 64'(b_if.out_valid), 64'd1);

    // Asynchronous reset between clock edges mid-stream.
    step_a(1'b1, 64'd1 << 59, 1'b0, 1'b0);
    chk("async_pre_data", 64'(a_if.out_data),   64'd1 << 59);
    chk("async_pre_lock", 64'(a_if.out_locked), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_valid",  64'(a_if.out_valid),  64'd0);
    chk("async_data",   64'(a_if.out_data),   64'd0);
    chk("async_locked", 64'(a_if.out_locked), 64'd0);
    #1;
    rst = 1'b0;
    step_a(1'b1, 64'd0, 1'b0, 1'b0);
    chk("async_post_data",  64'(a_if.out_data),  64'd0);
    chk("async_post_valid", 64'(a_if.out_valid), 64'd1);
    step_a(1'b0, 64'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
